// File: rtl/load_store_unit_if.sv
// Request, bus and writeback signals of the load/store unit.
// slave is the unit itself; master is the address-unit/memory side driving it.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  localparam int NB = WIDTH / 8;

  logic             i_valid;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_wdata;
  logic             i_store;
  logic [1:0]       i_size;
  logic             i_unsigned;
  logic             o_busy;
  logic             o_mem_req;
  logic             o_mem_we;
  logic [WIDTH-1:0] o_mem_addr;
  logic [WIDTH-1:0] o_mem_wdata;
  logic [NB-1:0]    o_mem_wstrb;
  logic             i_mem_ack;
  logic [WIDTH-1:0] i_mem_rdata;
  logic             o_valid;
  logic [WIDTH-1:0] o_rdata;
  logic             o_misaligned;

  modport slave (
    input  i_valid, i_addr, i_wdata, i_store, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
    output o_busy, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
           o_valid, o_rdata, o_misaligned
  );

  modport master (
    output i_valid, i_addr, i_wdata, i_store, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
    input  o_busy, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
           o_valid, o_rdata, o_misaligned
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto byte lanes, extracts and
// extends loads, and reports misaligned accesses without issuing a bus cycle.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  load_store_unit_if.slave  bus
);
  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [NB-1:0]    wstrb_q, wstrb_d;
  logic [LB-1:0]    lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             we_q, we_d;
  logic             uns_q, uns_d;
  logic             mis_q, mis_d;
  logic             fault;

  function automatic logic is_fault(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return (WIDTH == 32) ? 1'b1 : (a != 3'b000);
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_strb(input logic [1:0] size, input logic [LB-1:0] lane);
    return NB'(((32'd1 << (32'd1 << size)) - 32'd1) << lane);
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend to WIDTH.
  function automatic logic [WIDTH-1:0] extend_load(input logic [WIDTH-1:0] rdata,
                                                   input logic [1:0]       size,
                                                   input logic [LB-1:0]    lane,
                                                   input logic             uns);
    logic [WIDTH-1:0]  s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    s = rdata >> {lane, 3'b000};
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (size)
      2'd0:    return uns ? WIDTH'(s[7:0])  : WIDTH'(b);
      2'd1:    return uns ? WIDTH'(s[15:0]) : WIDTH'(h);
      2'd2:    return uns ? WIDTH'(s[31:0]) : WIDTH'(w);
      default: return s;
    endcase
  endfunction

  assign fault = is_fault(bus.i_size, bus.i_addr[2:0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wstrb_d = wstrb_q;
    lane_d  = lane_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          lane_d  = bus.i_addr[LB-1:0];
          addr_d  = {bus.i_addr[WIDTH-1:LB], {LB{1'b0}}};
          wdata_d = bus.i_wdata << {bus.i_addr[LB-1:0], 3'b000};
          wstrb_d = (bus.i_store && !fault) ? lane_strb(bus.i_size, bus.i_addr[LB-1:0]) : '0;
          we_d    = bus.i_store & ~fault;
          size_d  = bus.i_size;
          uns_d   = bus.i_unsigned;
          mis_d   = fault;
          rdata_d = '0;
          state_d = fault ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.i_mem_ack) begin
          if (!we_q) rdata_d = extend_load(bus.i_mem_rdata, size_q, lane_q, uns_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wstrb_q <= wstrb_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_mem_req    = (state_q == REQ);
  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign bus.o_mem_wstrb  = wstrb_q;
  assign bus.o_valid      = (state_q == DONE);
  assign bus.o_rdata      = (state_q == DONE) ? rdata_q : '0;
  assign bus.o_misaligned = (state_q == DONE) & mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (WIDTH=32): directed cases plus randomized accesses
// checked against an arithmetic model of the access rules.
module tb_load_store_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(W)) bus ();
  load_store_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  int          obs_vcnt, obs_vcyc, obs_reqcnt;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_strb;
  logic        obs_we, obs_mis, obs_unstable;

  function automatic logic model_fault(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] size,
                                            input logic store);
    longint unsigned m;
    if (!store) return 4'b0;
    m = ((64'd1 << (1 << size)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] addr, input logic [31:0] wd);
    longint unsigned v;
    v = longint'(wd) << (8 * (addr % 4));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] rd,
                                             input logic [1:0] size, input logic uns);
    longint unsigned v, mask;
    int nbits;
    nbits = 8 * (1 << size);
    v = longint'(rd) >> (8 * (addr % 4));
    mask = (64'd1 << nbits) - 1;
    v = v & mask;
    if (!uns && (((v >> (nbits - 1)) & 1) == 1)) v = v | ~mask;
    return v[31:0];
  endfunction

  // Drives one request, answers the bus after ack_dly extra REQ cycles and
  // compares everything observed against the model.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic store,
                         input logic [1:0] size, input logic uns, input int ack_dly,
                         input logic [31:0] rdata, input logic hold_valid, input string tag);
    logic        f;
    logic [31:0] exp_rd;
    int          exp_req;
    f = model_fault(addr, size);
    exp_rd = (f || store) ? 32'h0 : model_load(addr, rdata, size, uns);
    exp_req = f ? 0 : ack_dly + 1;
    obs_vcnt = 0; obs_vcyc = -1; obs_reqcnt = 0; obs_unstable = 1'b0;
    obs_addr = 'x; obs_wdata = 'x; obs_strb = 'x; obs_we = 1'bx; obs_rdata = 'x; obs_mis = 1'bx;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_addr = addr; bus.i_wdata = wdata;
    bus.i_store = store; bus.i_size = size; bus.i_unsigned = uns;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus.i_mem_ack = 1'b0;
      if (hold_valid) begin
        bus.i_addr = $urandom; bus.i_wdata = $urandom; bus.i_store = $urandom_range(0, 1);
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.o_mem_req) begin
        obs_reqcnt++;
        if (obs_reqcnt == 1) begin
          obs_addr = bus.o_mem_addr; obs_wdata = bus.o_mem_wdata;
          obs_strb = bus.o_mem_wstrb; obs_we = bus.o_mem_we;
        end else if (bus.o_mem_addr !== obs_addr || bus.o_mem_wdata !== obs_wdata ||
                     bus.o_mem_wstrb !== obs_strb || bus.o_mem_we !== obs_we) begin
          obs_unstable = 1'b1;
        end
        if (obs_reqcnt == ack_dly + 1) begin
          bus.i_mem_ack = 1'b1; bus.i_mem_rdata = rdata;
        end
      end
      if (bus.o_valid) begin
        obs_vcnt++; obs_vcyc = c; obs_rdata = bus.o_rdata; obs_mis = bus.o_misaligned;
        bus.i_valid = 1'b0;
        break;
      end
    end
    checks++;
    if (obs_vcnt !== 1) begin
      failures++; $display("FAIL %s o_valid_seen got=%0d want=1 (timeout)", tag, obs_vcnt);
    end
    checks++;
    if (obs_vcyc !== exp_req) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", tag, obs_vcyc, exp_req);
    end
    checks++;
    if (obs_mis !== f) begin
      failures++; $display("FAIL %s misaligned got=%b want=%b", tag, obs_mis, f);
    end
    checks++;
    if (obs_rdata !== exp_rd) begin
      failures++; $display("FAIL %s rdata got=%h want=%h", tag, obs_rdata, exp_rd);
    end
    checks++;
    if (obs_reqcnt !== exp_req) begin
      failures++; $display("FAIL %s req_cycles got=%0d want=%0d", tag, obs_reqcnt, exp_req);
    end
    if (!f) begin
      checks++;
      if (obs_addr !== (addr & 32'hFFFF_FFFC)) begin
        failures++; $display("FAIL %s mem_addr got=%h want=%h", tag, obs_addr, addr & 32'hFFFF_FFFC);
      end
      checks++;
      if (obs_we !== store) begin
        failures++; $display("FAIL %s mem_we got=%b want=%b", tag, obs_we, store);
      end
      checks++;
      if (obs_strb !== model_strb(addr, size, store)) begin
        failures++; $display("FAIL %s wstrb got=%b want=%b", tag, obs_strb, model_strb(addr, size, store));
      end
      if (store) begin
        checks++;
        if (obs_wdata !== model_wdata(addr, wdata)) begin
          failures++; $display("FAIL %s mem_wdata got=%h want=%h", tag, obs_wdata, model_wdata(addr, wdata));
        end
      end
      checks++;
      if (obs_unstable !== 1'b0) begin
        failures++; $display("FAIL %s bus_stable got=unstable want=stable", tag);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done valid=%b busy=%b want=0/0", tag, bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_mem_req, bus.o_mem_we, bus.o_valid, bus.o_misaligned} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b req=%b we=%b valid=%b mis=%b want all 0",
               bus.o_busy, bus.o_mem_req, bus.o_mem_we, bus.o_valid, bus.o_misaligned);
    end
    checks++;
    if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wstrb, bus.o_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h wstrb=%b rdata=%h want all 0",
               bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wstrb, bus.o_rdata);
    end
  endtask

  task automatic test_word_load();
    run_txn(32'h1004, 32'h0, 1'b0, 2'd2, 1'b0, 3, 32'hDEADBEEF, 1'b0, "word_load");
    checks++;
    if (obs_addr !== 32'h1004 || obs_strb !== 4'b0 || obs_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_load_fixed got addr=%h strb=%b rdata=%h want 00001004/0000/deadbeef",
               obs_addr, obs_strb, obs_rdata);
    end
  endtask

  task automatic test_byte_load();
    run_txn(32'h1003, 32'h0, 1'b0, 2'd0, 1'b0, 0, 32'h80FFFFFF, 1'b0, "byte_load_s");
    checks++;
    if (obs_rdata !== 32'hFFFFFF80) begin
      failures++; $display("FAIL byte_load_s_fixed got=%h want=ffffff80", obs_rdata);
    end
    run_txn(32'h1003, 32'h0, 1'b0, 2'd0, 1'b1, 1, 32'h80FFFFFF, 1'b0, "byte_load_u");
    checks++;
    if (obs_rdata !== 32'h00000080) begin
      failures++; $display("FAIL byte_load_u_fixed got=%h want=00000080", obs_rdata);
    end
  endtask

  task automatic test_half_store();
    run_txn(32'h2002, 32'h0000ABCD, 1'b1, 2'd1, 1'b0, 2, 32'h12345678, 1'b0, "half_store");
    checks++;
    if (obs_wdata !== 32'hABCD0000 || obs_strb !== 4'b1100 || obs_we !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++;
      $display("FAIL half_store_fixed got wdata=%h strb=%b we=%b rdata=%h want abcd0000/1100/1/0",
               obs_wdata, obs_strb, obs_we, obs_rdata);
    end
  endtask

  task automatic test_misaligned();
    run_txn(32'h2001, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'hFFFFFFFF, 1'b0, "mis_word");
    checks++;
    if (obs_reqcnt !== 0 || obs_mis !== 1'b1) begin
      failures++; $display("FAIL mis_word_fixed got req=%0d mis=%b want 0/1", obs_reqcnt, obs_mis);
    end
    run_txn(32'h2000, 32'h5555, 1'b1, 2'd3, 1'b0, 0, 32'hFFFFFFFF, 1'b0, "mis_dword");
    checks++;
    if (obs_reqcnt !== 0 || obs_mis !== 1'b1) begin
      failures++; $display("FAIL mis_dword_fixed got req=%0d mis=%b want 0/1", obs_reqcnt, obs_mis);
    end
    run_txn(32'h2003, 32'h5555, 1'b1, 2'd1, 1'b0, 0, 32'h0, 1'b0, "mis_half");
  endtask

  task automatic test_busy_ignore();
    run_txn(32'h3008, 32'h0, 1'b0, 2'd2, 1'b1, 4, 32'hCAFEF00D, 1'b1, "busy_ignore");
    checks++;
    if (obs_reqcnt !== 5 || obs_addr !== 32'h3008 || obs_vcnt !== 1) begin
      failures++; $display("FAIL busy_ignore_fixed got req=%0d addr=%h valids=%0d want 5/00003008/1",
                           obs_reqcnt, obs_addr, obs_vcnt);
    end
  endtask

  task automatic test_reset_during_req();
    int vseen, rseen;
    vseen = 0; rseen = 0;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_addr = 32'h4000; bus.i_store = 1'b0; bus.i_size = 2'd2; bus.i_unsigned = 1'b0;
    @(posedge clk); #1 bus.i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_mem_req !== 1'b1) begin
      failures++; $display("FAIL rst_req_started got=%b want=1", bus.o_mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_mem_req !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++; $display("FAIL rst_abandon got req=%b busy=%b valid=%b want 0/0/0",
                           bus.o_mem_req, bus.o_busy, bus.o_valid);
    end
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h11223344;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 bus.i_mem_ack = 1'b0;
      @(negedge clk);
      if (bus.o_valid) vseen++;
      if (bus.o_mem_req || bus.o_busy) rseen++;
    end
    checks++;
    if (vseen !== 0 || rseen !== 0) begin
      failures++; $display("FAIL rst_late_ack got valids=%0d busy_cycles=%0d want 0/0", vseen, rseen);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(32'h5000, 32'h01020304, 1'b1, 2'd2, 1'b0, 0, 32'h0, 1'b0, "b2b_0");
    run_txn(32'h5001, 32'h000000EE, 1'b1, 2'd0, 1'b0, 0, 32'h0, 1'b0, "b2b_1");
    run_txn(32'h5002, 32'h0, 1'b0, 2'd1, 1'b0, 0, 32'h8001_7F00, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(a, $urandom, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_store = 1'b0;
    bus.i_size = 2'd0; bus.i_unsigned = 1'b0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_busy_ignore();
    test_reset_during_req();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
